// File: rtl/instr_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory request/response, execute redirect and decoder handoff.
// The fetch unit uses the master modport; memory, execute and decoder together use the slave modport.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem fetches, buffers words in a FIFO
// and flushes stale responses on redirect. Define IFETCH_BYPASS_EN to forward responses straight to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master fetchBus
);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] fifoCount_q, fifoCount_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          reqValid_q, reqValid_d;
  logic [31:0]   instrMem_q [FIFO_DEPTH];
  logic [31:0]   pcMem_q    [FIFO_DEPTH];

  logic          reqFire;
  logic          rspFire;
  logic          redirTake;
  logic          bypassHit;
  logic          bypassTake;
  logic          push;
  logic          pop;
  logic [31:0]   rspPc;
  logic [31:0]   headInstr;
  logic [31:0]   headPc;
  logic [31:0]   outPc;
  logic [CW:0]   creditSum;

  // Outstanding requests in RUN are always consecutive words ending just below pc_q, so the
  // oldest one (the one now responding) sits outstanding_q words back.
  always_comb begin
    reqFire    = reqValid_q && fetchBus.imem_req_ready;
    rspFire    = fetchBus.imem_rsp_valid;
    redirTake  = fetchBus.redirect_valid && (state_q != BOOT);
    rspPc      = pc_q - {{(30-CW){1'b0}}, outstanding_q, 2'b00};
    headInstr  = instrMem_q[rdPtr_q];
    headPc     = pcMem_q[rdPtr_q];
`ifdef IFETCH_BYPASS_EN
    bypassHit  = (fifoCount_q == '0) && (state_q == RUN) && !redirTake && rspFire;
`else
    bypassHit  = 1'b0;
`endif
    bypassTake = bypassHit && fetchBus.if_ready;
    pop        = (fifoCount_q != '0) && fetchBus.if_ready;
    push       = (state_q == RUN) && rspFire && !redirTake && !bypassTake;

    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspFire);
    fifoCount_d   = fifoCount_q + CW'(push) - CW'(pop);
    wrPtr_d       = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d       = pop  ? rdPtr_q + PW'(1) : rdPtr_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (reqFire) pc_d = pc_q + 32'd4;
      FLUSH:   if (outstanding_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Every request still in flight after a redirect belongs to the old path and must be drained.
    if (redirTake) begin
      pc_d        = {fetchBus.redirect_pc[31:2], 2'b00};
      fifoCount_d = '0;
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      state_d     = (outstanding_d != '0) ? FLUSH : RUN;
    end

    creditSum  = {1'b0, fifoCount_d} + {1'b0, outstanding_d};
    reqValid_d = (state_d == RUN) && (creditSum < DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      fifoCount_q   <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      reqValid_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instrMem_q[i] <= NOP;
        pcMem_q[i]    <= RESET_PC;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      fifoCount_q   <= fifoCount_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      reqValid_q    <= reqValid_d;
      if (push) begin
        instrMem_q[wrPtr_q] <= fetchBus.imem_rsp_data;
        pcMem_q[wrPtr_q]    <= rspPc;
      end
    end
  end

  assign outPc                  = bypassHit ? rspPc : headPc;
  assign fetchBus.imem_req_valid = reqValid_q;
  assign fetchBus.imem_addr      = pc_q;
  assign fetchBus.if_valid       = bypassHit || (fifoCount_q != '0);
  assign fetchBus.if_instr       = bypassHit ? fetchBus.imem_rsp_data : headInstr;
  assign fetchBus.if_pc          = outPc;
  assign fetchBus.if_pc_plus4    = outPc + 32'd4;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, decoder back-pressure, redirect flush, PC wrap, async reset.
`timescale 1ns/1ps
module tb_instr_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if busA ();
  instr_fetch_if busB ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .fetchBus(busA)
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutB (
    .clk(clk), .rst_n(rst_n), .fetchBus(busB)
  );

  assign busA.imem_req_ready = 1'b1;
  assign busB.imem_req_ready = 1'b1;
  assign busB.if_ready       = 1'b1;
  assign busB.redirect_valid = 1'b0;
  assign busB.redirect_pc    = 32'h0;

  int          checkCount = 0;
  int          passCount  = 0;
  int          memLat     = 1;
  int          cycleCnt   = 0;
  logic        hsPendA = 1'b0, hsPendB = 1'b0;
  logic [31:0] hsAddrA, hsAddrB;
  logic [31:0] qAddr[$];
  int          qDue[$];
  logic [31:0] reqLogA[$], conPcA[$], conInstrA[$], conPlusA[$];
  logic [31:0] reqLogB[$], conPcB[$], conInstrB[$], conPlusB[$];
  int          baseReqA, baseConA, baseReqB, baseConB;
  int          firstValid;
  int          expFirst;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Handshakes and decoder consumption are observed mid-cycle, where every input is settled.
  always @(negedge clk) begin
    hsPendA = rst_n && busA.imem_req_valid && busA.imem_req_ready;
    hsAddrA = busA.imem_addr;
    hsPendB = rst_n && busB.imem_req_valid && busB.imem_req_ready;
    hsAddrB = busB.imem_addr;
    if (hsPendA) reqLogA.push_back(busA.imem_addr);
    if (hsPendB) reqLogB.push_back(busB.imem_addr);
    if (rst_n && busA.if_valid && busA.if_ready) begin
      conPcA.push_back(busA.if_pc);
      conInstrA.push_back(busA.if_instr);
      conPlusA.push_back(busA.if_pc_plus4);
    end
    if (rst_n && busB.if_valid && busB.if_ready) begin
      conPcB.push_back(busB.if_pc);
      conInstrB.push_back(busB.if_instr);
      conPlusB.push_back(busB.if_pc_plus4);
    end
  end

  // In-order memory with memLat cycles of latency for A, fixed single-cycle latency for B.
  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
    if (!rst_n) begin
      qAddr.delete();
      qDue.delete();
      busA.imem_rsp_valid <= 1'b0;
      busA.imem_rsp_data  <= 32'h0;
      busB.imem_rsp_valid <= 1'b0;
      busB.imem_rsp_data  <= 32'h0;
    end else begin
      if (hsPendA) begin
        qAddr.push_back(hsAddrA);
        qDue.push_back(cycleCnt + memLat - 1);
      end
      if (qAddr.size() != 0 && qDue[0] <= cycleCnt) begin
        busA.imem_rsp_valid <= 1'b1;
        busA.imem_rsp_data  <= memWord(qAddr[0]);
        void'(qAddr.pop_front());
        void'(qDue.pop_front());
      end else begin
        busA.imem_rsp_valid <= 1'b0;
      end
      busB.imem_rsp_valid <= hsPendB;
      busB.imem_rsp_data  <= memWord(hsAddrB);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic ifReady, input logic redirValid, input logic [31:0] redirPc);
    busA.if_ready       = ifReady;
    busA.redirect_valid = redirValid;
    busA.redirect_pc    = redirPc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic markLogs();
    baseReqA = reqLogA.size();
    baseConA = conPcA.size();
    baseReqB = reqLogB.size();
    baseConB = conPcB.size();
  endtask

  task automatic applyReset(input int lat);
    rst_n  = 1'b0;
    memLat = lat;
    repeat (3) tick();
    markLogs();
    rst_n = 1'b1;
  endtask

  function automatic int nReqA();  return reqLogA.size() - baseReqA; endfunction
  function automatic int nConA();  return conPcA.size() - baseConA;  endfunction
  function automatic int nReqB();  return reqLogB.size() - baseReqB; endfunction
  function automatic int nConB();  return conPcB.size() - baseConB;  endfunction
  function automatic logic [31:0] reqA(input int k);   return reqLogA[baseReqA + k];   endfunction
  function automatic logic [31:0] pcA(input int k);    return conPcA[baseConA + k];    endfunction
  function automatic logic [31:0] instrA(input int k); return conInstrA[baseConA + k]; endfunction
  function automatic logic [31:0] plusA(input int k);  return conPlusA[baseConA + k];  endfunction
  function automatic logic [31:0] reqB(input int k);   return reqLogB[baseReqB + k];   endfunction
  function automatic logic [31:0] pcB(input int k);    return conPcB[baseConB + k];    endfunction
  function automatic logic [31:0] instrB(input int k); return conInstrB[baseConB + k]; endfunction
  function automatic logic [31:0] plusB(input int k);  return conPlusB[baseConB + k];  endfunction

  initial begin
`ifdef IFETCH_BYPASS_EN
    expFirst = 2;
`else
    expFirst = 3;
`endif
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (2) tick();
    checkOutput("rstReqValid", 32'(busA.imem_req_valid), 32'h0);
    checkOutput("rstIfValid",  32'(busA.if_valid), 32'h0);
    checkOutput("rstInstr",    busA.if_instr, 32'h0000_0013);
    checkOutput("rstPc",       busA.if_pc, 32'h0);
    checkOutput("rstPcPlus4",  busA.if_pc_plus4, 32'h4);
    checkOutput("rstPcB",      busB.if_pc, 32'hFFFF_FFF8);
    checkOutput("rstPcPlus4B", busB.if_pc_plus4, 32'hFFFF_FFFC);

    // Streaming with 1-cycle memory and an always-ready decoder.
    markLogs();
    rst_n      = 1'b1;
    firstValid = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (firstValid == 0 && busA.if_valid) firstValid = n;
    end
    checkOutput("firstValidCycle", firstValid, expFirst);
    checkOutput("streamReqCount", (nReqA() >= 3) ? 1 : 0, 1);
    checkOutput("streamReq0", reqA(0), 32'h0);
    checkOutput("streamReq1", reqA(1), 32'h4);
    checkOutput("streamReq2", reqA(2), 32'h8);
    checkOutput("streamConCount", (nConA() >= 3) ? 1 : 0, 1);
    checkOutput("streamPc0", pcA(0), 32'h0);
    checkOutput("streamPc1", pcA(1), 32'h4);
    checkOutput("streamPc2", pcA(2), 32'h8);
    checkOutput("streamPlus0", plusA(0), 32'h4);
    checkOutput("streamPlus1", plusA(1), 32'h8);
    checkOutput("streamPlus2", plusA(2), 32'hC);
    checkOutput("streamInstr0", instrA(0), 32'hC0DE_0000);
    checkOutput("streamInstr2", instrA(2), 32'hC0DE_0008);
    checkOutput("wrapReqCount", (nReqB() >= 3) ? 1 : 0, 1);
    checkOutput("wrapReq0", reqB(0), 32'hFFFF_FFF8);
    checkOutput("wrapReq1", reqB(1), 32'hFFFF_FFFC);
    checkOutput("wrapReq2", reqB(2), 32'h0000_0000);
    checkOutput("wrapConCount", (nConB() >= 3) ? 1 : 0, 1);
    checkOutput("wrapPc1", pcB(1), 32'hFFFF_FFFC);
    checkOutput("wrapPlus1", plusB(1), 32'h0000_0000);
    checkOutput("wrapPc2", pcB(2), 32'h0000_0000);
    checkOutput("wrapInstr2", instrB(2), 32'hC0DE_0000);

    // Decoder stalled: the credit limit caps issue at two requests.
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyReset(1);
    repeat (12) tick();
    checkOutput("stallReqCount", nReqA(), 2);
    checkOutput("stallReqValid", 32'(busA.imem_req_valid), 32'h0);
    checkOutput("stallIfValid",  32'(busA.if_valid), 32'h1);
    checkOutput("stallHeadPc",   busA.if_pc, 32'h0);
    checkOutput("stallConCount", nConA(), 0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (20) tick();
    checkOutput("drainConCount", (nConA() >= 4) ? 1 : 0, 1);
    checkOutput("drainPc0", pcA(0), 32'h0);
    checkOutput("drainPc1", pcA(1), 32'h4);
    checkOutput("drainPc2", pcA(2), 32'h8);
    checkOutput("drainPc3", pcA(3), 32'hC);
    checkOutput("drainInstr3", instrA(3), 32'hC0DE_000C);

    // Redirect to 0x100 while two 3-cycle responses are in flight.
    applyReset(3);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    markLogs();
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("flushReqValid0", 32'(busA.imem_req_valid), 32'h0);
    checkOutput("flushIfValid0",  32'(busA.if_valid), 32'h0);
    checkOutput("flushAddr",      busA.imem_addr, 32'h0000_0100);
    tick();
    checkOutput("flushReqValid1", 32'(busA.imem_req_valid), 32'h0);
    tick();
    checkOutput("flushDoneReqValid", 32'(busA.imem_req_valid), 32'h1);
    checkOutput("flushDoneAddr",     busA.imem_addr, 32'h0000_0100);
    repeat (20) tick();
    checkOutput("redirReqCount", (nReqA() >= 1) ? 1 : 0, 1);
    checkOutput("redirReq0",     reqA(0), 32'h0000_0100);
    checkOutput("redirConCount", (nConA() >= 1) ? 1 : 0, 1);
    checkOutput("redirPc0",      pcA(0), 32'h0000_0100);
    checkOutput("redirInstr0",   instrA(0), 32'hC0DE_0100);

    // Redirect to unaligned 0x203 coinciding with a response and a request handshake.
    applyReset(1);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0203);
    markLogs();
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("sameCycIfValid0",  32'(busA.if_valid), 32'h0);
    checkOutput("sameCycReqValid0", 32'(busA.imem_req_valid), 32'h0);
    checkOutput("alignAddr",        busA.imem_addr, 32'h0000_0200);
    tick();
    checkOutput("sameCycIfValid1",  32'(busA.if_valid), 32'h0);
    checkOutput("sameCycReqValid1", 32'(busA.imem_req_valid), 32'h1);
    repeat (20) tick();
    checkOutput("sameCycReqCount", (nReqA() >= 2) ? 1 : 0, 1);
    checkOutput("sameCycStaleReq", reqA(0), 32'h4);
    checkOutput("sameCycReq1",     reqA(1), 32'h0000_0200);
    checkOutput("sameCycConCount", (nConA() >= 1) ? 1 : 0, 1);
    checkOutput("sameCycPc0",      pcA(0), 32'h0000_0200);
    checkOutput("sameCycInstr0",   instrA(0), 32'hC0DE_0200);

    // Asynchronous reset while draining stale responses.
    applyReset(3);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("preRstAddr", busA.imem_addr, 32'h0000_0100);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncAddr",     busA.imem_addr, 32'h0);
    checkOutput("asyncReqValid", 32'(busA.imem_req_valid), 32'h0);
    checkOutput("asyncIfValid",  32'(busA.if_valid), 32'h0);
    checkOutput("asyncInstr",    busA.if_instr, 32'h0000_0013);
    checkOutput("asyncPcPlus4",  busA.if_pc_plus4, 32'h4);
    applyReset(1);
    repeat (20) tick();
    checkOutput("restartReqCount", (nReqA() >= 1) ? 1 : 0, 1);
    checkOutput("restartReq0",     reqA(0), 32'h0);
    checkOutput("restartConCount", (nConA() >= 1) ? 1 : 0, 1);
    checkOutput("restartPc0",      pcA(0), 32'h0);
    checkOutput("restartInstr0",   instrA(0), 32'hC0DE_0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request port with an in-order response port.
- Buffers returned instructions in a small FIFO and presents instruction, PC and PC+4 to the decoder with a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute; a redirect flushes the FIFO and discards stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be word aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2; also caps in-flight requests.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  fetch address, equals current pc.
- imem_rsp_valid  input  1  response valid; responses return in request order, cannot be back-pressured.
- imem_rsp_data  input  32  fetched instruction word.
- redirect_valid  input  1  one-cycle pulse: change control flow.
- redirect_pc  input  32  new fetch PC.
- if_valid  output  1  instruction available to decoder.
- if_ready  input  1  decoder consumes instruction.
- if_instr  output  32  instruction to decoder.
- if_pc  output  32  address of if_instr.
- if_pc_plus4  output  32  if_pc + 4 (JAL/JALR link value).

Behaviour:
- Reset (async assert, sync release): pc = RESET_PC, FIFO empty, outstanding = 0, state = BOOT. imem_req_valid = 0, if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = RESET_PC, if_pc_plus4 = RESET_PC + 4.
- FSM states:
  - BOOT: exactly one cycle, then RUN.
  - RUN: normal fetch.
  - FLUSH: draining stale responses.
- Issue (RUN only): imem_req_valid = (fifo_count + outstanding) < FIFO_DEPTH. On req handshake: outstanding += 1; pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- Response (RUN): on imem_rsp_valid, outstanding -= 1; {imem_rsp_data, pc of that request} is pushed into the FIFO. The credit rule guarantees no overflow. Push and pop in the same cycle are legal when the FIFO is full.
- Output: if_valid = FIFO non-empty; head is registered. Pop on if_valid && if_ready. Response-to-if_valid latency is 1 cycle.
- Redirect (any state except BOOT; priority over every other event that cycle):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; a response arriving in the same cycle is dropped.
  - if_valid = 0 on the next cycle.
- Stale count after a redirect = outstanding, including any request that handshakes in the redirect cycle, minus any response that arrives in that cycle.
  - Stale count > 0: next state FLUSH, stale counter loaded.
  - Stale count = 0: RUN.
- FLUSH:
  - imem_req_valid = 0.
  - Each imem_rsp_valid decrements the stale counter and the data is discarded.
  - Counter reaching 0 -> RUN on the next cycle.
  - A redirect while in FLUSH updates pc, stays in FLUSH, and keeps the current count.
- Redirect during BOOT is ignored.
- A mid-operation reset abandons outstanding requests. The memory side must be reset together with this block.
- if_pc_plus4 is computed from the head pc (wrapping add).

Optional Feature:
- Macro IFETCH_BYPASS_EN.
- Defined: when the FIFO is empty and the state is RUN with no redirect, an arriving response is driven combinationally onto if_instr/if_pc with if_valid = 1. If if_ready = 1, it is consumed without entering the FIFO (0-cycle latency); otherwise it is pushed as normal.
- Undefined: the output is strictly registered, with 1-cycle latency.
- Redirect, flush and credit rules are identical in both builds.

Test Plan:
- Reset release, memory always ready, 1-cycle response, if_ready = 1:
  - Requests at 0x0, 0x4, 0x8 on consecutive cycles.
  - if_pc 0x0, 0x4, 0x8 presented back-to-back; if_pc_plus4 = 0x4, 0x8, 0xC.
  - First if_valid at cycle 3 after release (2 with bypass).
- if_ready = 0 with FIFO_DEPTH = 2: exactly 2 requests issued, then imem_req_valid = 0 until if_ready rises. No instruction is lost and order is preserved.
- Redirect to 0x100 with 2 responses outstanding:
  - FSM enters FLUSH and both responses are discarded.
  - Next request is at 0x100; first if_pc after the redirect = 0x100.
- Redirect in the same cycle as imem_rsp_valid and a request handshake: the response is dropped, the request is counted as stale, and no instruction from the old path reaches if_valid.
- redirect_pc = 0x203: next imem_addr = 0x200.
- RESET_PC = 0xFFFF_FFF8: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); if_pc_plus4 of 0xFFFF_FFFC = 0x0.
- Reset asserted while in FLUSH: all outputs return to reset values immediately (asynchronous), and fetch restarts at RESET_PC.
